// File: rtl/foobar_monitor.sv
// -----------------------------------------------------------------------------
// foobar_monitor
// Receive-side checker for the foo/bar pulse streams. Each stream has its own
// channel that locks to the expected pulse spacing, counts received pulses and
// records missing/extra pulses as sticky flags plus saturating error counts.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// foobar_monitor_chan
// One HUNT/LOCK channel. Tracks the position inside the expected period with a
// phase counter and classifies every enabled sample as good, extra or missing.
// -----------------------------------------------------------------------------
module foobar_monitor_chan #(
    parameter int P     = 3,
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             pulse_i,
    output logic [CNT_W-1:0] count_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             err_evt_o
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Phase runs 0..P-1; P >= 2 keeps the width at least one bit.
    localparam int              PH_W    = (P > 1) ? $clog2(P) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(P - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_e           state_q;
    logic [PH_W-1:0]  phase_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             at_last_s;
    logic             extra_s;
    logic             missing_s;
    logic             err_evt_s;

    // Classify the current enabled sample against the locked phase.
    always_comb begin
        at_last_s = (phase_q == PH_LAST);
        extra_s   = 1'b0;
        missing_s = 1'b0;
        if (en_i && (state_q == LOCK)) begin
            extra_s   = pulse_i && !at_last_s;
            missing_s = !pulse_i && at_last_s;
        end else begin
            extra_s   = 1'b0;
            missing_s = 1'b0;
        end
        err_evt_s = extra_s | missing_s;
    end

    // Channel FSM, phase, pulse counter and error statistics.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q   <= HUNT;
            phase_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (en_i) begin
            case (state_q)
                HUNT: begin
                    // First pulse seen defines the phase reference.
                    if (pulse_i) begin
                        state_q <= LOCK;
                        phase_q <= '0;
                        count_q <= count_q + CNT_W'(1);
                    end else begin
                        state_q <= HUNT;
                    end
                end
                LOCK: begin
                    if (pulse_i) begin
                        // Good or extra pulse: either way resync on it.
                        state_q <= LOCK;
                        phase_q <= '0;
                        count_q <= count_q + CNT_W'(1);
                    end else if (at_last_s) begin
                        // Expected slot passed empty: lose lock.
                        state_q <= HUNT;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                default: begin
                    state_q <= HUNT;
                    phase_q <= '0;
                end
            endcase

            if (err_evt_s) begin
                err_q <= 1'b1;
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                end else begin
                    err_cnt_q <= err_cnt_q;
                end
            end else begin
                err_q     <= err_q;
                err_cnt_q <= err_cnt_q;
            end
        end else begin
            state_q   <= state_q;
            phase_q   <= phase_q;
            count_q   <= count_q;
            err_q     <= err_q;
            err_cnt_q <= err_cnt_q;
        end
    end

    assign count_o   = count_q;
    assign locked_o  = (state_q == LOCK);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    // Qualified by en: an error event this cycle sets the sticky flag on this edge.
    assign err_evt_o = err_evt_s;

endmodule

// -----------------------------------------------------------------------------
// foobar_monitor (top)
// Two independent channels plus a registered combined error flag.
// -----------------------------------------------------------------------------
module foobar_monitor #(
    parameter int FOO_PERIOD = 3,
    parameter int BAR_PERIOD = 5,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             foo,
    input  logic             bar,
    output logic [CNT_W-1:0] count_foo,
    output logic [CNT_W-1:0] count_bar,
    output logic             foo_locked,
    output logic             bar_locked,
    output logic             err_foo,
    output logic             err_bar,
    output logic [ERR_W-1:0] err_cnt_foo,
    output logic [ERR_W-1:0] err_cnt_bar,
    output logic             err_any
);

    logic foo_evt_s;
    logic bar_evt_s;
    logic err_any_q;

    foobar_monitor_chan #(
        .P     (FOO_PERIOD),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) u_foo (
        .clk       (clk),
        .rst_ni    (rst),
        .en_i      (en),
        .pulse_i   (foo),
        .count_o   (count_foo),
        .locked_o  (foo_locked),
        .err_o     (err_foo),
        .err_cnt_o (err_cnt_foo),
        .err_evt_o (foo_evt_s)
    );

    foobar_monitor_chan #(
        .P     (BAR_PERIOD),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) u_bar (
        .clk       (clk),
        .rst_ni    (rst),
        .en_i      (en),
        .pulse_i   (bar),
        .count_o   (count_bar),
        .locked_o  (bar_locked),
        .err_o     (err_bar),
        .err_cnt_o (err_cnt_bar),
        .err_evt_o (bar_evt_s)
    );

    // Combined sticky flag, set on the same edge as either channel flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_any_q <= 1'b0;
        end else if (en) begin
            err_any_q <= err_any_q | foo_evt_s | bar_evt_s;
        end else begin
            err_any_q <= err_any_q;
        end
    end

    assign err_any = err_any_q;

endmodule

// File: tb/tb_foobar_monitor.sv
// -----------------------------------------------------------------------------
// tb_foobar_monitor
// Directed stimulus with hand-computed expectations. The driver queues the
// expected output values after each step; a monitor on the falling edge pops
// and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_foobar_monitor;

    localparam int S_CF  = 0;
    localparam int S_CB  = 1;
    localparam int S_FL  = 2;
    localparam int S_BL  = 3;
    localparam int S_EF  = 4;
    localparam int S_EB  = 5;
    localparam int S_ECF = 6;
    localparam int S_ECB = 7;
    localparam int S_EA  = 8;

    typedef struct {
        int    cyc;
        string name;
        int    sel;
        int    exp_val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       foo;
    logic       bar;
    logic [7:0] count_foo;
    logic [7:0] count_bar;
    logic       foo_locked;
    logic       bar_locked;
    logic       err_foo;
    logic       err_bar;
    logic [3:0] err_cnt_foo;
    logic [3:0] err_cnt_bar;
    logic       err_any;

    int   cyc;
    int   checks;
    int   errors;
    int   t;
    int   bar_res;
    exp_t sb_q[$];

    foobar_monitor #(
        .FOO_PERIOD (3),
        .BAR_PERIOD (5),
        .CNT_W      (8),
        .ERR_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .foo         (foo),
        .bar         (bar),
        .count_foo   (count_foo),
        .count_bar   (count_bar),
        .foo_locked  (foo_locked),
        .bar_locked  (bar_locked),
        .err_foo     (err_foo),
        .err_bar     (err_bar),
        .err_cnt_foo (err_cnt_foo),
        .err_cnt_bar (err_cnt_bar),
        .err_any     (err_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to tag expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_field(input int sel);
        case (sel)
            S_CF:    return int'(count_foo);
            S_CB:    return int'(count_bar);
            S_FL:    return int'(foo_locked);
            S_BL:    return int'(bar_locked);
            S_EF:    return int'(err_foo);
            S_EB:    return int'(err_bar);
            S_ECF:   return int'(err_cnt_foo);
            S_ECB:   return int'(err_cnt_bar);
            S_EA:    return int'(err_any);
            default: return -1;
        endcase
    endfunction

    function automatic string field_name(input int sel);
        case (sel)
            S_CF:    return "count_foo";
            S_CB:    return "count_bar";
            S_FL:    return "foo_locked";
            S_BL:    return "bar_locked";
            S_EF:    return "err_foo";
            S_EB:    return "err_bar";
            S_ECF:   return "err_cnt_foo";
            S_ECB:   return "err_cnt_bar";
            S_EA:    return "err_any";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e      = sb_q.pop_front();
            act    = get_field(e.sel);
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s %s: expectation for cycle %0d seen at cycle %0d",
                         e.name, field_name(e.sel), e.cyc, cyc);
            end else if (act != e.exp_val) begin
                errors = errors + 1;
                $display("FAIL %s %s: got %0d expected %0d",
                         e.name, field_name(e.sel), act, e.exp_val);
            end
        end
    end

    task automatic chk(input string name, input int sel, input int val);
        exp_t e;
        e.cyc     = cyc;
        e.name    = name;
        e.sel     = sel;
        e.exp_val = val;
        sb_q.push_back(e);
    endtask

    task automatic chk_all(input string name, input int cf, input int cb,
                           input int fl, input int bl, input int ef, input int eb,
                           input int ecf, input int ecb, input int ea);
        chk(name, S_CF, cf);
        chk(name, S_CB, cb);
        chk(name, S_FL, fl);
        chk(name, S_BL, bl);
        chk(name, S_EF, ef);
        chk(name, S_EB, eb);
        chk(name, S_ECF, ecf);
        chk(name, S_ECB, ecb);
        chk(name, S_EA, ea);
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic b);
        rst = r;
        en  = e;
        foo = f;
        bar = b;
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        bar_res = 4;
        rst = 1'b0; en = 1'b1; foo = 1'b1; bar = 1'b1;

        // Reset with pulses present and en high.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Clean stream: foo on 2,5,8..; bar on 4,9,14..
        for (t = 0; t < 30; t++) begin
            step(1'b1, 1'b1, (t % 3) == 2, (t % 5) == bar_res);
            if (t == 1) chk("lock_foo_pre", S_FL, 0);
            if (t == 2) chk("lock_foo", S_FL, 1);
            if (t == 3) chk("lock_bar_pre", S_BL, 0);
            if (t == 4) chk("lock_bar", S_BL, 1);
        end
        chk_all("clean", 10, 6, 1, 1, 0, 0, 0, 0, 0);

        // Missing foo pulse at t=41, relock at t=44.
        for (t = 30; t < 45; t++) begin
            step(1'b1, 1'b1, ((t % 3) == 2) && (t != 41), (t % 5) == bar_res);
            if (t == 40) chk("miss_pre", S_FL, 1);
            if (t == 41) chk_all("missing", 13, 8, 0, 1, 1, 0, 1, 0, 1);
        end
        chk_all("relock", 14, 9, 1, 1, 1, 0, 1, 0, 1);

        // Extra bar pulse at t=51, two cycles after the good one at t=49.
        for (t = 45; t < 57; t++) begin
            step(1'b1, 1'b1, (t % 3) == 2, ((t % 5) == bar_res) || (t == 51));
            if (t == 51) begin
                chk_all("extra", 16, 11, 1, 1, 1, 1, 1, 1, 1);
                bar_res = 1;
            end
        end
        chk_all("after_extra", 18, 12, 1, 1, 1, 1, 1, 1, 1);

        // en low for 7 cycles with pulses present: everything frozen.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 0) chk("gap_first", S_CF, 18);
        end
        chk_all("gap", 18, 12, 1, 1, 1, 1, 1, 1, 1);

        // Resume the stream where it stopped.
        for (t = 57; t < 71; t++) begin
            step(1'b1, 1'b1, (t % 3) == 2, (t % 5) == bar_res);
        end
        chk_all("resume", 22, 14, 1, 1, 1, 1, 1, 1, 1);

        // Reset in the middle of a locked stream with errors recorded.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 256 clean foo pulses from reset: counter wraps to 0.
        for (t = 0; t < 768; t++) begin
            step(1'b1, 1'b1, (t % 3) == 2, 1'b0);
            if (t == 764) chk("wrap_255", S_CF, 255);
        end
        chk_all("wrap", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Bar high every cycle: one lock then 20 extra pulses.
        for (int k = 0; k < 21; k++) begin
            t = 768 + k;
            step(1'b1, 1'b1, (t % 3) == 2, 1'b1);
            if (k == 0)  chk("sat_lock", S_ECB, 0);
            if (k == 14) chk("sat_14", S_ECB, 14);
            if (k == 15) chk("sat_15", S_ECB, 15);
            if (k == 16) chk("sat_16", S_ECB, 15);
        end
        chk_all("saturate", 7, 21, 1, 1, 0, 1, 0, 15, 1);

        // Final reset.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("final_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Let the monitor drain the queue.
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/foobar_monitor.md
Name: foobar_monitor

Overview:
- Receive-side checker for the foo/bar pulse streams that foobar produces.
- Samples foo and bar each enabled cycle, locks to each stream's period, and counts the pulses it receives on its own.
- Flags missing and extra pulses, and keeps sticky and saturating error statistics.
- Sits alongside foobar in system benches and on-chip self-test paths, fed from the same clk/en.

Parameters:
- FOO_PERIOD, 3, expected foo pulse spacing in enabled cycles (>=2)
- BAR_PERIOD, 5, expected bar pulse spacing in enabled cycles (>=2)
- CNT_W, 8, width of the received-pulse counters
- ERR_W, 4, width of the saturating error counters

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- en  in  1  sample enable; when 0, all state holds
- foo  in  1  foo pulse stream (one-cycle-high pulses)
- bar  in  1  bar pulse stream
- count_foo  out  CNT_W  foo pulses received
- count_bar  out  CNT_W  bar pulses received
- foo_locked  out  1  foo channel in LOCK
- bar_locked  out  1  bar channel in LOCK
- err_foo  out  1  sticky foo error flag
- err_bar  out  1  sticky bar error flag
- err_cnt_foo  out  ERR_W  foo error count, saturating
- err_cnt_bar  out  ERR_W  bar error count, saturating
- err_any  out  1  err_foo OR err_bar (registered)

Behaviour:
- All outputs are registered. Inputs sampled at edge k are reflected in outputs after edge k (1-cycle latency).
- Reset: at a posedge with rst==0, every output is cleared to 0, both channels go to HUNT, and phase=0. Reset has priority over en. Reset applied mid-stream discards all lock, count and error state on that edge.
- en==0: channel state, phase, counts and errors all hold. Pulses present while en==0 are ignored and cause no errors.
- Each channel (foo with P=FOO_PERIOD, bar with P=BAR_PERIOD) runs an independent 2-state FSM, HUNT/LOCK, with a phase counter of clog2(P) bits.
- HUNT, pulse=1: go to LOCK, phase:=0, count++. No error.
- HUNT, pulse=0: stay in HUNT.
- LOCK, pulse=1, phase==P-1: good pulse. count++, phase:=0.
- LOCK, pulse=1, phase!=P-1: extra pulse. Error event, count++, phase:=0 (resync), stay in LOCK.
- LOCK, pulse=0, phase==P-1: missing pulse. Error event, go to HUNT, phase:=0.
- LOCK, pulse=0, otherwise: phase++.
- Error event: err_x:=1 (sticky until reset). err_cnt_x increments, saturating at 2^ERR_W-1.
- Counts wrap modulo 2^CNT_W with no flag.
- foo and bar are fully independent. Simultaneous foo and bar pulses in the same cycle are legal and each is processed by its own channel.
- err_any updates on the same edge as whichever sticky flag sets.
- x_locked equals (state==LOCK).

Test Plan:
- Reset: hold rst=0 for 2 cycles with foo=bar=1 and en=1 -> all outputs 0 and both locked=0. Then release rst.
- Clean stream: en=1, foo high on enabled cycles 2,5,8,... and bar high on 4,9,14,..., 30 cycles -> foo_locked=1 after cycle 2, bar_locked=1 after cycle 4, count_foo=10, count_bar=6, err_any=0.
- Missing foo: drop the 4th foo pulse -> err_foo=1, err_cnt_foo=1 and foo_locked=0 one cycle after the expected slot. Relocks on the next foo. Bar counts and flags are unchanged.
- Extra bar: inject a bar pulse 2 cycles after a good bar pulse -> err_bar=1, err_cnt_bar=1, count_bar +1, bar_locked stays 1. The next pulse 5 cycles later is accepted with no new error.
- en gating: deassert en for 7 cycles mid-stream (stream also paused) -> counts, phase and flags frozen with no error. Resume -> stream continues locked with no error.
- Boundaries: 256 clean foo pulses from reset -> count_foo wraps to 0. 20 injected bar errors with ERR_W=4 -> err_cnt_bar=15. Reset asserted mid-stream -> all outputs 0 on the next edge.
